// File: rtl/intr_controller.sv
// rtl/intr_controller.sv - prioritised, maskable, non-nesting interrupt controller
module intr_controller #(
    parameter int                   NUM_SRC    = 4,
    parameter int                   PC_WIDTH   = 32,
    parameter int                   ID_WIDTH   = 2,
    parameter logic [PC_WIDTH-1:0]  VEC_BASE   = PC_WIDTH'(1024),
    parameter logic [PC_WIDTH-1:0]  VEC_STRIDE = PC_WIDTH'(16),
    parameter logic [NUM_SRC-1:0]   MASK_RESET = '0
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [NUM_SRC-1:0]   i_irq_in,
    input  logic                 i_global_en,
    input  logic                 i_cpu_safe,
    input  logic [PC_WIDTH-1:0]  i_pc_current,
    input  logic                 i_mask_wr,
    input  logic [NUM_SRC-1:0]   i_mask_data,
    input  logic                 i_iret,
    output logic                 o_intr_take,
    output logic [PC_WIDTH-1:0]  o_intr_vector,
    output logic [ID_WIDTH-1:0]  o_intr_id,
    output logic [PC_WIDTH-1:0]  o_epc,
    output logic                 o_intr_return,
    output logic                 o_in_service,
    output logic [NUM_SRC-1:0]   o_pending,
    output logic [NUM_SRC-1:0]   o_mask
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TAKE    = 2'd1,
        ST_SERVICE = 2'd2,
        ST_RETURN  = 2'd3
    } state_t;

    state_t                r_state;
    logic [NUM_SRC-1:0]    r_irq_prev;
    logic [NUM_SRC-1:0]    r_pending;
    logic [NUM_SRC-1:0]    r_mask;
    logic [PC_WIDTH-1:0]   r_epc;
    logic [PC_WIDTH-1:0]   r_intr_vector;
    logic [ID_WIDTH-1:0]   r_intr_id;
    logic                  r_intr_take;
    logic                  r_intr_return;
    logic                  r_in_service;
    logic                  r_iret_pend;

    logic [NUM_SRC-1:0]    w_rise;
    logic [NUM_SRC-1:0]    w_eligible;
    logic [ID_WIDTH-1:0]   w_sel;
    logic                  w_take_go;
    logic [NUM_SRC-1:0]    w_clr;
    logic [PC_WIDTH-1:0]   w_sel_ext;
    logic [PC_WIDTH-1:0]   w_vector;

    assign w_rise     = i_irq_in & ~r_irq_prev;
    assign w_eligible = r_pending & r_mask;
    assign w_take_go  = (r_state == ST_IDLE) && (|w_eligible) && i_global_en && i_cpu_safe;
    assign w_clr      = w_take_go ? (NUM_SRC'(1) << w_sel) : '0;
    assign w_sel_ext  = PC_WIDTH'(w_sel);
    assign w_vector   = VEC_BASE + w_sel_ext * VEC_STRIDE;

    // Lowest-index eligible source wins; scan from the top so the lowest overwrites last.
    always_comb begin
        w_sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_sel = ID_WIDTH'(i);
            end
        end
    end

    // Edge capture, pending accumulation (new edge beats take-clear) and mask register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_irq_prev <= '0;
            r_pending  <= '0;
            r_mask     <= MASK_RESET;
        end else begin
            r_irq_prev <= i_irq_in;
            r_pending  <= (r_pending & ~w_clr) | w_rise;
            if (i_mask_wr) begin
                r_mask <= i_mask_data;
            end
        end
    end

    // Service FSM with registered take/return pulses and saved context.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_epc         <= '0;
            r_intr_id     <= '0;
            r_intr_vector <= VEC_BASE;
            r_intr_take   <= 1'b0;
            r_intr_return <= 1'b0;
            r_in_service  <= 1'b0;
            r_iret_pend   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_intr_return <= 1'b0;
                    r_iret_pend   <= 1'b0;
                    if (w_take_go) begin
                        r_state       <= ST_TAKE;
                        r_epc         <= i_pc_current;
                        r_intr_id     <= w_sel;
                        r_intr_vector <= w_vector;
                        r_intr_take   <= 1'b1;
                        r_in_service  <= 1'b1;
                    end
                end
                ST_TAKE: begin
                    r_state     <= ST_SERVICE;
                    r_intr_take <= 1'b0;
                    r_iret_pend <= i_iret;
                end
                ST_SERVICE: begin
                    if (i_iret || r_iret_pend) begin
                        r_state       <= ST_RETURN;
                        r_intr_return <= 1'b1;
                        r_in_service  <= 1'b0;
                        r_iret_pend   <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_intr_return <= 1'b0;
                    r_iret_pend   <= 1'b0;
                end
            endcase
        end
    end

    assign o_intr_take   = r_intr_take;
    assign o_intr_vector = r_intr_vector;
    assign o_intr_id     = r_intr_id;
    assign o_epc         = r_epc;
    assign o_intr_return = r_intr_return;
    assign o_in_service  = r_in_service;
    assign o_pending     = r_pending;
    assign o_mask        = r_mask;

endmodule
